// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the integrate-and-fire network sequencer.
package if_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Layer-select field of the weight-memory address.
  localparam int LAYER_SEL_MSB = 31;
  localparam int LAYER_SEL_LSB = 28;

  // Width of the winner index; a single output still needs one bit.
  function automatic int winner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/if_spike_counter.sv
// One saturating per-output spike counter with synchronous clear and enable.
module if_spike_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority; increment stops at the all-ones value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/if_network_ctrl.sv
// Sequencer between host streams and the IF network: weight load, then
// clear / timestep feed / pipeline drain / spike counting with argmax.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for cmd_load / cmd_run
// LOAD     | streaming weight words into the layer memories
// CLEAR    | one cycle of network reset before a run
// RUN      | accepting spike timesteps until num_steps handshakes
// DRAIN    | NUM_LAYERS+1 cycles flushing network latency, still counting
// DONE     | result held, winner valid, new commands accepted
module if_network_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int          NUM_INPUTS       = 4,
  parameter int          NUM_OUTPUTS      = 2,
  parameter int          NUM_LAYERS       = 2,
  parameter logic [31:0] LAYER_WORDS [NUM_LAYERS] = '{32'h2, 32'h8},
  parameter int          WEIGHT_SIZE      = 32,
  parameter int          LAYER_ADDR_WIDTH = 28,
  parameter int          STEP_W           = 16,
  parameter int          CNT_W            = 16,
  localparam int         WIN_W            = winner_width(NUM_OUTPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_load,
  input  logic                         cmd_run,
  input  logic [STEP_W-1:0]            num_steps,
  output logic                         busy,
  output logic                         load_done,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [WEIGHT_SIZE-1:0]       w_data,
  input  logic                         spk_valid,
  output logic                         spk_ready,
  input  logic [NUM_INPUTS-1:0]        spk_data,
  output logic                         net_rst,
  output logic [NUM_INPUTS-1:0]        net_spike_in,
  input  logic [NUM_OUTPUTS-1:0]       net_spike_out,
  output logic [31:0]                  mem_addr,
  output logic [WEIGHT_SIZE-1:0]       mem_din,
  output logic                         mem_wen,
  output logic                         result_valid,
  output logic [NUM_OUTPUTS*CNT_W-1:0] out_counts,
  output logic [WIN_W-1:0]             winner
);

  // Layer index is one bit wider than the 4-bit select so that
  // "past the last layer" is representable.
  localparam logic [4:0] LAST_PLUS1 = 5'(NUM_LAYERS);

  state_t                    state_q, state_d;
  logic [4:0]                layer_q, layer_d;
  logic [LAYER_ADDR_WIDTH-1:0] local_q, local_d;
  logic                      mem_wen_q, mem_wen_d;
  logic [31:0]               mem_addr_q, mem_addr_d;
  logic [WEIGHT_SIZE-1:0]    mem_din_q, mem_din_d;
  logic                      load_done_q, load_done_d;
  logic [STEP_W-1:0]         steps_q, steps_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [NUM_INPUTS-1:0]     spk_in_q, spk_in_d;
  logic [4:0]                drain_q, drain_d;
  logic                      cnt_clr;
  logic                      cnt_en;
  logic [4:0]                nxt_layer;
  logic [CNT_W-1:0]          cnt [NUM_OUTPUTS];

  // Word count of a layer; out-of-range indices read as empty.
  function automatic logic [31:0] words_of(input logic [4:0] l);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (l == 5'(i)) w = LAYER_WORDS[i];
    end
    return w;
  endfunction

  // First layer at or after 'from' that has words, or NUM_LAYERS if none.
  function automatic logic [4:0] first_layer(input logic [4:0] from);
    logic [4:0] r;
    r = LAST_PLUS1;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if ((5'(i) >= from) && (LAYER_WORDS[i] != 32'd0)) r = 5'(i);
    end
    return r;
  endfunction

  assign w_ready   = (state_q == ST_LOAD) && (layer_q < LAST_PLUS1);
  assign spk_ready = (state_q == ST_RUN);
  assign cnt_en    = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    local_d     = local_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    load_done_d = 1'b0;
    steps_d     = steps_q;
    step_d      = step_q;
    spk_in_d    = '0;
    drain_d     = drain_q;
    cnt_clr     = 1'b0;
    nxt_layer   = first_layer(layer_q + 5'd1);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_load) begin
          state_d = ST_LOAD;
          layer_d = first_layer(5'd0);
          local_d = '0;
        end else if (cmd_run) begin
          state_d = ST_CLEAR;
          steps_d = num_steps;
          step_d  = '0;
          cnt_clr = 1'b1;
        end
      end

      ST_LOAD: begin
        if (layer_q >= LAST_PLUS1) begin
          // Every layer is empty: nothing to write.
          state_d     = ST_IDLE;
          load_done_d = 1'b1;
        end else if (w_valid) begin
          mem_wen_d  = 1'b1;
          mem_addr_d = '0;
          mem_addr_d[LAYER_SEL_MSB:LAYER_SEL_LSB] = layer_q[3:0];
          mem_addr_d[LAYER_ADDR_WIDTH-1:0]        = local_q;
          mem_din_d  = w_data;
          if (32'(local_q) == words_of(layer_q) - 32'd1) begin
            local_d = '0;
            layer_d = nxt_layer;
            if (nxt_layer >= LAST_PLUS1) begin
              state_d     = ST_IDLE;
              load_done_d = 1'b1;
            end
          end else begin
            local_d = local_q + LAYER_ADDR_WIDTH'(1);
          end
        end
      end

      ST_CLEAR: begin
        if (steps_q == '0) begin
          state_d = ST_DRAIN;
          drain_d = LAST_PLUS1;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (spk_valid) begin
          spk_in_d = spk_data;
          step_d   = step_q + STEP_W'(1);
          if (step_q + STEP_W'(1) == steps_q) begin
            state_d = ST_DRAIN;
            drain_d = LAST_PLUS1;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_q == 5'd0) state_d = ST_DONE;
        else                 drain_d = drain_q - 5'd1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset drops any in-flight write and partial load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      local_q     <= '0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      load_done_q <= 1'b0;
      steps_q     <= '0;
      step_q      <= '0;
      spk_in_q    <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      local_q     <= local_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      load_done_q <= load_done_d;
      steps_q     <= steps_d;
      step_q      <= step_d;
      spk_in_q    <= spk_in_d;
      drain_q     <= drain_d;
    end
  end

  for (genvar n = 0; n < NUM_OUTPUTS; n++) begin : g_cnt
    if_spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .inc   (net_spike_out[n]),
      .count (cnt[n])
    );
    assign out_counts[n*CNT_W +: CNT_W] = cnt[n];
  end

  // Argmax over held counts; strict compare keeps the lowest index on ties.
  always_comb begin
    logic [CNT_W-1:0] best;
    best   = cnt[0];
    winner = '0;
    for (int n = 1; n < NUM_OUTPUTS; n++) begin
      if (cnt[n] > best) begin
        best   = cnt[n];
        winner = WIN_W'(n);
      end
    end
  end

  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign result_valid = (state_q == ST_DONE);
  assign net_rst      = rst || (state_q == ST_CLEAR);
  assign net_spike_in = spk_in_q;
  assign mem_wen      = mem_wen_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign load_done    = load_done_q;

endmodule

// File: tb/tb_if_network_ctrl.sv
// Bench for if_network_ctrl: directed load/run scenarios plus a per-cycle
// reference model of the weight-write stream, spike forwarding and argmax.
module tb_if_network_ctrl;

  localparam int NI  = 4;
  localparam int NO  = 2;
  localparam int NL  = 2;
  localparam int WS  = 32;
  localparam int SW  = 16;
  localparam int CW  = 2;
  localparam int LW0 = 2;
  localparam int LW1 = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_load = 1'b0;
  logic           cmd_run = 1'b0;
  logic [SW-1:0]  num_steps = '0;
  logic           busy;
  logic           load_done;
  logic           w_valid = 1'b0;
  logic           w_ready;
  logic [WS-1:0]  w_data = '0;
  logic           spk_valid = 1'b0;
  logic           spk_ready;
  logic [NI-1:0]  spk_data = '0;
  logic           net_rst;
  logic [NI-1:0]  net_spike_in;
  logic [NO-1:0]  net_spike_out = '0;
  logic [31:0]    mem_addr;
  logic [WS-1:0]  mem_din;
  logic           mem_wen;
  logic           result_valid;
  logic [NO*CW-1:0] out_counts;
  logic [0:0]     winner;

  always #5 clk = ~clk;

  if_network_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_load      (cmd_load),
    .cmd_run       (cmd_run),
    .num_steps     (num_steps),
    .busy          (busy),
    .load_done     (load_done),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .spk_valid     (spk_valid),
    .spk_ready     (spk_ready),
    .spk_data      (spk_data),
    .net_rst       (net_rst),
    .net_spike_in  (net_spike_in),
    .net_spike_out (net_spike_out),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_wen       (mem_wen),
    .result_valid  (result_valid),
    .out_counts    (out_counts),
    .winner        (winner)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Model state
  logic [31:0]   addr_list[$];
  logic [31:0]   log_addr[$];
  logic [31:0]   log_data[$];
  bit            exp_wen = 0;
  bit            exp_ld  = 0;
  logic [31:0]   exp_addr = '0;
  logic [WS-1:0] exp_din  = '0;
  logic [NI-1:0] exp_spk  = '0;
  bit            chk_en = 0;
  int            wen_cnt = 0, ld_cnt = 0, hs_cnt = 0;
  int            busy_cyc = 0, nrst_cyc = 0, srdy_cyc = 0;

  function automatic logic [0:0] ref_winner(input logic [NO*CW-1:0] oc);
    int best;
    int idx;
    best = -1;
    idx  = 0;
    for (int n = 0; n < NO; n++) begin
      if (int'(oc[n*CW +: CW]) > best) begin
        best = int'(oc[n*CW +: CW]);
        idx  = n;
      end
    end
    return 1'(idx);
  endfunction

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_wen", mem_wen, exp_wen);
      if (exp_wen && mem_wen) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_din", mem_din, exp_din);
      end
      chk("load_done", load_done, exp_ld);
      chk("net_spike_in", net_spike_in, exp_spk);
      if (result_valid) chk("winner", winner, ref_winner(out_counts));
      if (mem_wen) begin
        wen_cnt++;
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_din);
      end
      if (load_done) ld_cnt++;
      if (busy) busy_cyc++;
      if (net_rst && !rst) nrst_cyc++;
      if (spk_ready) srdy_cyc++;
    end
    exp_wen = 0;
    exp_ld  = 0;
    exp_spk = '0;
    if (rst) begin
      addr_list.delete();
    end else begin
      if (w_valid && w_ready) begin
        if (addr_list.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=handshake required=none");
        end else begin
          exp_addr = addr_list.pop_front();
          exp_din  = w_data;
          exp_wen  = 1;
          exp_ld   = (addr_list.size() == 0);
        end
      end
      if (spk_valid && spk_ready) begin
        exp_spk = spk_data;
        hs_cnt++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic build_load_list();
    int words;
    addr_list.delete();
    for (int l = 0; l < NL; l++) begin
      words = (l == 0) ? LW0 : LW1;
      for (int i = 0; i < words; i++) addr_list.push_back({4'(l), 28'(i)});
    end
  endtask

  task automatic send_words(input logic [31:0] base, input int n, input bit gap);
    int  guard;
    bit  done;
    for (int i = 0; i < n; i++) begin
      guard   = 0;
      done    = 0;
      w_data  = base + 32'(i);
      w_valid = 1'b1;
      while (!done && guard < 50) begin
        @(negedge clk);
        done = w_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL w_handshake_timeout actual=no_ready required=ready");
      end
      w_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    @(negedge clk);
    while (!result_valid && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!result_valid) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  task automatic start_run(input logic [SW-1:0] steps);
    num_steps = steps;
    cmd_run   = 1'b1;
    tick();
    cmd_run   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_net_rst", net_rst, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_spk_ready", spk_ready, 0);
    chk("rst_out_counts", out_counts, 0);
    chk("rst_winner", winner, 0);
    chk("rst_load_done", load_done, 0);
    tick();
    rst    = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("idle_net_rst", net_rst, 0);
    tick();

    // Continuous load of 10 words
    build_load_list();
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    @(negedge clk);
    chk("load_busy", busy, 1);
    chk("load_w_ready", w_ready, 1);
    tick();
    send_words(32'hA0, 10, 0);
    tick(3);
    chk("load1_writes", wen_cnt, 10);
    chk("load1_done_pulses", ld_cnt, 1);
    chk("load1_addr0", log_addr[0], 32'h0000_0000);
    chk("load1_addr1", log_addr[1], 32'h0000_0001);
    chk("load1_addr2", log_addr[2], 32'h1000_0000);
    chk("load1_addr9", log_addr[9], 32'h1000_0007);
    chk("load1_data0", log_data[0], 32'hA0);
    chk("load1_data9", log_data[9], 32'hA9);
    chk("load1_idle", busy, 0);

    // Load with w_valid every other cycle
    wen_cnt = 0;
    log_addr.delete();
    log_data.delete();
    build_load_list();
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    send_words(32'hB0, 10, 1);
    tick(3);
    chk("load2_writes", wen_cnt, 10);
    chk("load2_done_pulses", ld_cnt, 2);
    chk("load2_addr5", log_addr[5], 32'h1000_0003);
    chk("load2_data9", log_data[9], 32'hB9);

    // Run: 3 steps, output neuron 1 spikes twice
    hs_cnt = 0; busy_cyc = 0; nrst_cyc = 0;
    spk_data  = 4'hF;
    spk_valid = 1'b1;
    start_run(3);
    @(negedge clk);
    chk("clear_net_rst", net_rst, 1);
    chk("clear_spk_ready", spk_ready, 0);
    chk("clear_busy", busy, 1);
    tick();
    net_spike_out = 2'b10;
    tick(2);
    net_spike_out = 2'b00;
    wait_done();
    chk("run3_counts", out_counts, 4'b1000);
    chk("run3_winner", winner, 1);
    chk("run3_result_valid", result_valid, 1);
    chk("run3_busy", busy, 0);
    chk("run3_handshakes", hs_cnt, 3);
    chk("run3_net_rst_cycles", nrst_cyc, 1);
    chk("run3_busy_cycles", busy_cyc, 7);
    tick();

    // Saturation: neuron 0 spikes on 6 counted cycles, CNT_W=2 -> 3
    hs_cnt = 0;
    start_run(4);
    @(negedge clk);
    chk("sat_clear_counts", out_counts, 0);
    tick();
    net_spike_out = 2'b01;
    tick(6);
    net_spike_out = 2'b00;
    wait_done();
    chk("sat_counts", out_counts, 4'b0011);
    chk("sat_winner", winner, 0);
    chk("sat_handshakes", hs_cnt, 4);
    tick();

    // Tie: both neurons count 2 -> lowest index wins
    start_run(2);
    tick();
    net_spike_out = 2'b11;
    tick(2);
    net_spike_out = 2'b00;
    wait_done();
    chk("tie_counts", out_counts, 4'b1010);
    chk("tie_winner", winner, 0);
    tick();

    // Zero steps: CLEAR then DRAIN only
    hs_cnt = 0; busy_cyc = 0; srdy_cyc = 0;
    start_run(0);
    wait_done();
    chk("zero_spk_ready_cycles", srdy_cyc, 0);
    chk("zero_busy_cycles", busy_cyc, 4);
    chk("zero_counts", out_counts, 0);
    chk("zero_handshakes", hs_cnt, 0);
    chk("zero_result_valid", result_valid, 1);
    spk_valid = 1'b0;
    tick();

    // Reset to IDLE, then simultaneous commands: load wins
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_result_valid", result_valid, 0);
    chk("rst_idle_busy", busy, 0);
    tick();
    wen_cnt = 0;
    build_load_list();
    num_steps = 5;
    cmd_load  = 1'b1;
    cmd_run   = 1'b1;
    tick();
    cmd_load  = 1'b0;
    cmd_run   = 1'b0;
    @(negedge clk);
    chk("both_cmd_w_ready", w_ready, 1);
    chk("both_cmd_net_rst", net_rst, 0);
    tick();
    send_words(32'hC0, 2, 0);
    num_steps = 1;
    cmd_run   = 1'b1;
    tick();
    cmd_run   = 1'b0;
    @(negedge clk);
    chk("run_ignored_w_ready", w_ready, 1);
    chk("run_ignored_net_rst", net_rst, 0);
    tick();
    send_words(32'hC2, 2, 0);
    w_data  = 32'hC4;
    w_valid = 1'b1;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    tick(5);
    w_valid = 1'b0;
    @(negedge clk);
    chk("abort_writes", wen_cnt, 4);
    chk("abort_busy", busy, 0);
    chk("abort_w_ready", w_ready, 0);
    chk("abort_no_load_done", ld_cnt, 2);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
